// File: rtl/controle.sv
// controle: registered RV32I main control decoder forming the ID/EX control field.
module controle (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    output logic       mem_to_reg_out,
    output logic       reg_write_out,
    output logic       mem_read_out,
    output logic       mem_write_out,
    output logic       beq_instruction_out,
    output logic       aluSrc_out,
    output logic [1:0] aluOp_out
);
    logic [7:0] w_ctrl;
    logic [7:0] r_ctrl;
    // {mem_to_reg, reg_write, mem_read, mem_write, beq, aluSrc, aluOp}
    always_comb begin
        w_ctrl = (opcode == 7'b0110011) ? 8'b0100_0010 :
                 (opcode == 7'b0000011) ? 8'b1110_0100 :
                 (opcode == 7'b0100011) ? 8'b0001_0100 :
                 (opcode == 7'b1100011) ? 8'b0000_1001 : 8'b0000_0000;
    end
    always_ff @(posedge clock) begin
        if (!reset) r_ctrl <= 8'b0;
        else        r_ctrl <= w_ctrl;
    end
    assign {mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
            beq_instruction_out, aluSrc_out, aluOp_out} = r_ctrl;
endmodule

// File: tb/tb_controle.sv
// tb_controle: directed self-checking bench for the controle decoder.
module tb_controle;
    logic       clock;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out;
    logic       beq_instruction_out, aluSrc_out;
    logic [1:0] aluOp_out;
    logic [7:0] obs;
    int checks = 0;
    int errors = 0;

    localparam logic [7:0] V_NOP = 8'b0000_0000;
    localparam logic [7:0] V_R   = 8'b0100_0010;
    localparam logic [7:0] V_LD  = 8'b1110_0100;
    localparam logic [7:0] V_ST  = 8'b0001_0100;
    localparam logic [7:0] V_BR  = 8'b0000_1001;

    controle dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .beq_instruction_out(beq_instruction_out), .aluSrc_out(aluSrc_out),
        .aluOp_out(aluOp_out)
    );

    assign obs = {mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
                  beq_instruction_out, aluSrc_out, aluOp_out};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; opcode = 7'b0110011;
        step();
        checks++;
        if (obs !== V_NOP) begin errors++; $display("FAIL reset_first got %b exp %b", obs, V_NOP); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (obs !== V_NOP) begin errors++; $display("FAIL reset_hold%0d got %b exp %b", k, obs, V_NOP); end
        end
    endtask

    task automatic test_rtype();
        reset = 1'b1; opcode = 7'b0110011;
        step();
        checks++;
        if (obs !== V_R) begin errors++; $display("FAIL rtype got %b exp %b", obs, V_R); end
    endtask

    task automatic test_back_to_back();
        opcode = 7'b0000011;
        step();
        checks++;
        if (obs !== V_LD) begin errors++; $display("FAIL b2b_load got %b exp %b", obs, V_LD); end
        opcode = 7'b0100011;
        step();
        checks++;
        if (obs !== V_ST) begin errors++; $display("FAIL b2b_store got %b exp %b", obs, V_ST); end
    endtask

    task automatic test_branch();
        opcode = 7'b1100011;
        step();
        checks++;
        if (obs !== V_BR) begin errors++; $display("FAIL branch got %b exp %b", obs, V_BR); end
        #2 opcode = 7'b1111111;
        #1;
        checks++;
        if (obs !== V_BR) begin errors++; $display("FAIL branch_midcycle got %b exp %b", obs, V_BR); end
        step();
        checks++;
        if (obs !== V_NOP) begin errors++; $display("FAIL branch_then_unknown got %b exp %b", obs, V_NOP); end
    endtask

    task automatic test_unknown();
        logic [7:0] exp_v;
        opcode = 7'b0000000;
        step();
        checks++;
        if (obs !== V_NOP) begin errors++; $display("FAIL unknown_zero got %b exp %b", obs, V_NOP); end
        for (int op = 0; op < 128; op++) begin
            opcode = 7'(op);
            step();
            exp_v = (op == 'h33) ? V_R : (op == 'h03) ? V_LD :
                    (op == 'h23) ? V_ST : (op == 'h63) ? V_BR : V_NOP;
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL sweep op=%b got %b exp %b", opcode, obs, exp_v); end
            checks++;
            if ((mem_read_out && mem_write_out) || (reg_write_out && mem_write_out)) begin
                errors++; $display("FAIL exclusive op=%b got %b exp no conflict", opcode, obs);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; opcode = 7'b0110011;
        step();
        checks++;
        if (obs !== V_R) begin errors++; $display("FAIL mid_pre got %b exp %b", obs, V_R); end
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== V_R) begin errors++; $display("FAIL async_glitch got %b exp %b", obs, V_R); end
        reset = 1'b0;
        step();
        checks++;
        if (obs !== V_NOP) begin errors++; $display("FAIL mid_reset got %b exp %b", obs, V_NOP); end
        reset = 1'b1;
        step();
        checks++;
        if (obs !== V_R) begin errors++; $display("FAIL mid_release got %b exp %b", obs, V_R); end
    endtask

    initial begin
        reset = 1'b0;
        opcode = 7'b0;
        @(negedge clock);
        test_reset();
        test_rtype();
        test_back_to_back();
        test_branch();
        test_unknown();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
